// File: rtl/melody_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// melody_sequencer: steps a note ROM and drives tone divisor/enable with a
// per-note duration and an inter-note gap. Define MELODY_LOOP_EN to replay.
// Rev 1.0
// ----------------------------------------------------------------------------
module melody_sequencer #(
  parameter int TICK_DIV  = 500000,
  parameter int GAP_TICKS = 2,
  parameter int DIV_W     = 18,
  parameter int N_NOTES   = 16,
  parameter logic [N_NOTES*(DIV_W+6)-1:0] ROM_INIT = {
    {DIV_W'(18'd0),     6'd0 },   // 15
    {DIV_W'(18'd0),     6'd0 },   // 14
    {DIV_W'(18'd0),     6'd0 },   // 13 end of melody
    {DIV_W'(18'd95420), 6'd40},   // 12 C4
    {DIV_W'(18'd75758), 6'd20},   // 11 E4
    {DIV_W'(18'd63776), 6'd20},   // 10 G4
    {DIV_W'(18'd0),     6'd10},   //  9 rest
    {DIV_W'(18'd47801), 6'd40},   //  8 C5
    {DIV_W'(18'd50607), 6'd20},   //  7 B4
    {DIV_W'(18'd56818), 6'd20},   //  6 A4
    {DIV_W'(18'd0),     6'd10},   //  5 rest
    {DIV_W'(18'd63776), 6'd40},   //  4 G4
    {DIV_W'(18'd71633), 6'd20},   //  3 F4
    {DIV_W'(18'd75758), 6'd20},   //  2 E4
    {DIV_W'(18'd85034), 6'd20},   //  1 D4
    {DIV_W'(18'd95420), 6'd20}    //  0 C4
  }
) (
  input  logic                       iCLK,
  input  logic                       iRST,
  input  logic                       iSTART,
  input  logic                       iSTOP,
  output logic [DIV_W-1:0]           oTONE_DIV,
  output logic                       oTONE_EN,
  output logic [$clog2(N_NOTES)-1:0] oNOTE_IDX,
  output logic                       oBUSY,
  output logic                       oDONE
);

  localparam int c_idx_w   = $clog2(N_NOTES);
  localparam int c_entry_w = DIV_W + 6;
  localparam int c_pre_w   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_gap_w   = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [c_idx_w-1:0]   idx_q,   idx_d;
  logic [DIV_W-1:0]     div_q,   div_d;
  logic                 en_q,    en_d;
  logic                 busy_q,  busy_d;
  logic                 done_q,  done_d;
  logic [c_pre_w-1:0]   pre_q,   pre_d;
  logic [5:0]           dur_q,   dur_d;
  logic [c_gap_w-1:0]   gap_q,   gap_d;

  logic [c_entry_w-1:0] rom [N_NOTES];
  logic [DIV_W-1:0]     w_rom_div;
  logic [5:0]           w_rom_dur;
  logic                 w_tick;

  for (genvar g = 0; g < N_NOTES; g++) begin : g_rom
    assign rom[g] = ROM_INIT[g*c_entry_w +: c_entry_w];
  end

  assign w_rom_div = rom[idx_q][c_entry_w-1:6];
  assign w_rom_dur = rom[idx_q][5:0];
  assign w_tick    = (pre_q == c_pre_w'(TICK_DIV - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    div_d   = div_q;
    en_d    = en_q;
    done_d  = 1'b0;
    dur_d   = dur_q;
    gap_d   = gap_q;
    pre_d   = w_tick ? '0 : pre_q + c_pre_w'(1);

    if (iSTOP) begin
      state_d = S_IDLE;
      idx_d   = '0;
      div_d   = '0;
      en_d    = 1'b0;
      dur_d   = '0;
      gap_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iSTART) begin
            state_d = S_LOAD;
            idx_d   = '0;
          end
        end

        S_LOAD: begin
          // Restarting the prescaler here makes every note an exact tick multiple.
          pre_d = '0;
          if (w_rom_dur == 6'd0) begin
            done_d = 1'b1;
            idx_d  = '0;
`ifdef MELODY_LOOP_EN
            state_d = S_LOAD;
`else
            state_d = S_IDLE;
            div_d   = '0;
            en_d    = 1'b0;
`endif
          end else begin
            div_d   = w_rom_div;
            en_d    = (w_rom_div != '0);
            dur_d   = w_rom_dur;
            state_d = S_PLAY;
          end
        end

        S_PLAY: begin
          if (w_tick) begin
            if (dur_q == 6'd1) begin
              dur_d = '0;
              if (GAP_TICKS > 0) begin
                state_d = S_GAP;
                gap_d   = c_gap_w'(GAP_TICKS);
                en_d    = 1'b0;
              end else begin
                state_d = S_LOAD;
                idx_d   = idx_q + c_idx_w'(1);
              end
            end else begin
              dur_d = dur_q - 6'd1;
            end
          end
        end

        S_GAP: begin
          if (w_tick) begin
            if (gap_q == c_gap_w'(1)) begin
              gap_d   = '0;
              state_d = S_LOAD;
              idx_d   = idx_q + c_idx_w'(1);
            end else begin
              gap_d = gap_q - c_gap_w'(1);
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      div_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pre_q   <= '0;
      dur_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pre_q   <= pre_d;
      dur_q   <= dur_d;
      gap_q   <= gap_d;
    end
  end

  assign oTONE_DIV = div_q;
  assign oTONE_EN  = en_q;
  assign oNOTE_IDX = idx_q;
  assign oBUSY     = busy_q;
  assign oDONE     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_melody_sequencer: directed stimulus against a cycle-trace model of the melody.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_melody_sequencer;

  localparam int TICK = 4;
  localparam int GAPT = 1;
  localparam logic [16*24-1:0] ROM = {
    288'd0,
    18'd0,   6'd0,
    18'd200, 6'd3,
    18'd0,   6'd1,
    18'd100, 6'd2
  };

  int tbl_div [16] = '{100, 0, 200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int tbl_dur [16] = '{2, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [17:0] tone_div;
  logic        tone_en;
  logic [3:0]  note_idx;
  logic        busy;
  logic        done;

  typedef struct {
    int div;
    int en;
    int idx;
    int busy;
    int done;
  } exp_t;

  exp_t exp_q [$];
  exp_t exp_now;
  int   vectors = 0;
  int   miscompares = 0;

  melody_sequencer #(
    .TICK_DIV (TICK),
    .GAP_TICKS(GAPT),
    .DIV_W    (18),
    .N_NOTES  (16),
    .ROM_INIT (ROM)
  ) dut (
    .iCLK     (clk),
    .iRST     (rst),
    .iSTART   (start),
    .iSTOP    (stop),
    .oTONE_DIV(tone_div),
    .oTONE_EN (tone_en),
    .oNOTE_IDX(note_idx),
    .oBUSY    (busy),
    .oDONE    (done)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(int d, int e, int i, int b, int dn);
    exp_t t;
    t.div = d; t.en = e; t.idx = i; t.busy = b; t.done = dn;
    return t;
  endfunction

  // Expand the note table into the expected per-cycle output trace of one pass.
  function automatic void build_trace();
    int cur_div = 0;
    int cur_en  = 0;
    int idx     = 0;
    exp_q.delete();
    for (int n = 0; n < 64; n++) begin
      exp_q.push_back(mk(cur_div, cur_en, idx, 1, 0));
      if (tbl_dur[idx] == 0) begin
        exp_q.push_back(mk(0, 0, 0, 0, 1));
        break;
      end
      cur_div = tbl_div[idx];
      cur_en  = (cur_div != 0) ? 1 : 0;
      repeat (tbl_dur[idx] * TICK) exp_q.push_back(mk(cur_div, cur_en, idx, 1, 0));
      cur_en = 0;
      repeat (GAPT * TICK) exp_q.push_back(mk(cur_div, cur_en, idx, 1, 0));
      idx = (idx + 1) % 16;
    end
  endfunction

  always @(posedge clk) begin
    if (rst || stop) begin
      exp_q.delete();
      exp_now <= mk(0, 0, 0, 0, 0);
    end else if (exp_q.size() > 0) begin
      exp_now <= exp_q.pop_front();
    end else if (start && exp_now.busy == 0) begin
      build_trace();
      if (exp_q.size() != 41) begin
        miscompares++;
        $display("FAIL trace_len actual=%0d required=41", exp_q.size());
      end
      vectors++;
      exp_now <= exp_q.pop_front();
    end else begin
      exp_now <= mk(0, 0, 0, 0, 0);
    end
  end

  always @(negedge clk) begin
    vectors++;
    if (int'(tone_div) != exp_now.div || int'(tone_en) != exp_now.en ||
        int'(note_idx) != exp_now.idx || int'(busy) != exp_now.busy ||
        int'(done) != exp_now.done) begin
      miscompares++;
      $display("FAIL cycle t=%0t actual div=%0d en=%0d idx=%0d busy=%0d done=%0d required div=%0d en=%0d idx=%0d busy=%0d done=%0d",
               $time, tone_div, tone_en, note_idx, busy, done,
               exp_now.div, exp_now.en, exp_now.idx, exp_now.busy, exp_now.done);
    end
  end

  task automatic check(input string name, input int actual, input int required);
    vectors++;
    if (actual != required) begin
      miscompares++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic check_silent(input string name);
    check({name, "_div"},  int'(tone_div), 0);
    check({name, "_en"},   int'(tone_en), 0);
    check({name, "_idx"},  int'(note_idx), 0);
    check({name, "_busy"}, int'(busy), 0);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Starts a pass; n counts negedges after the start edge until oDONE.
  task automatic run_to_done(input int poke_at, output int n);
    pulse_start();
    n = 1;
    while (!done && n < 200) begin
      start = (n == poke_at);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!done) begin
      miscompares++;
      $display("FAIL done_timeout actual=%0d required=41", n);
    end
  endtask

  initial begin
    int n;
    int done_cnt;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_silent("reset");
    check("reset_done", int'(done), 0);
    rst = 1'b0;

    // Full pass: 4 loads + 36 note/gap cycles, oDONE on the 41st.
    run_to_done(0, n);
    check("play_done_cycle", n, 41);
    check("play_busy_drop", int'(busy), 0);
    repeat (3) @(negedge clk);

    // Abort during entry 2.
    pulse_start();
    n = 0;
    while (!(note_idx == 4'd2 && tone_en) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_idx2", int'(note_idx), 2);
    repeat (3) @(negedge clk);
    stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    check_silent("abort");
    done_cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);

    // start+stop together in IDLE: stop wins.
    @(negedge clk) begin start = 1'b1; stop = 1'b1; end
    @(negedge clk) begin start = 1'b0; stop = 1'b0; end
    check("collision_busy", int'(busy), 0);
    repeat (2) @(negedge clk);

    // Second start in PLAY must not restart the pass.
    run_to_done(4, n);
    check("ignored_start_done_cycle", n, 41);
    repeat (3) @(negedge clk);

    // Reset in cycle 5 of entry 0, then a clean restart.
    pulse_start();
    @(negedge clk);
    check("latency_en", int'(tone_en), 1);
    check("latency_div", int'(tone_div), 100);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_silent("midreset");
    repeat (2) @(negedge clk);
    run_to_done(0, n);
    check("restart_done_cycle", n, 41);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
